// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the divide issue/writeback sequencer.
package div_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned DIV_CYCLES_DEF = 100;
    localparam logic [DATA_W-1:0] DIVZ_QUOT = 32'hFFFF_FFFF;

    // One-hot state encoding
    localparam int unsigned ST_W = 5;
    localparam logic [ST_W-1:0] ST_IDLE    = 5'b00001;
    localparam logic [ST_W-1:0] ST_ISSUE   = 5'b00010;
    localparam logic [ST_W-1:0] ST_WAIT    = 5'b00100;
    localparam logic [ST_W-1:0] ST_CAPTURE = 5'b01000;
    localparam logic [ST_W-1:0] ST_FIX     = 5'b10000;

    typedef enum logic [ST_W-1:0] {
        S_IDLE    = ST_IDLE,
        S_ISSUE   = ST_ISSUE,
        S_WAIT    = ST_WAIT,
        S_CAPTURE = ST_CAPTURE,
        S_FIX     = ST_FIX
    } state_e;

    // Magnitude of an operand: two's-complement absolute value when signed, raw otherwise
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
        return (sgn && x[DATA_W-1]) ? DATA_W'(-x) : x;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bus between a requester and the divide sequencer.
interface div_ctrl_if;
    import div_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_signed;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              resp_valid;
    logic              busy;

    modport master (
        output req_valid, req_signed, rs, rt,
        input  req_ready, busy, hi, lo, resp_valid
    );

    modport slave (
        input  req_valid, req_signed, rs, rt,
        output req_ready, busy, hi, lo, resp_valid
    );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate used to restore the sign of quotient/remainder.
module div_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] val,
    output logic [W-1:0] y_c
);

    // Negate when the architectural result is negative
    always_comb begin
        y_c = neg ? W'(-val) : val;
    end

endmodule

// File: rtl/div_ctrl.sv
// Divide issue/writeback sequencer: magnitude conversion, core start/ack handshake,
// fixed-latency wait, sign correction and HI/LO writeback. Divide-by-zero is resolved
// locally. Optional macro DIV_FASTPATH_EN: |rt|==1 bypasses the core.
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned W          = DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    div_ctrl_if.slave      bus,
    output logic           div_start,
    output logic           div_ack,
    output logic [2*W-1:0] div_dividend,
    output logic [W-1:0]   div_divisor,
    input  logic [W-1:0]   div_quotient,
    input  logic [2*W-1:0] div_remainder
);

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rs_q;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W-1:0]  q_raw;
    logic [W-1:0]  r_raw;
    logic          neg_q;
    logic          neg_r;
    logic          dz;
    logic [W-1:0]  hi_q;
    logic [W-1:0]  lo_q;
    logic          resp_q;

    logic          accept_c;
    logic [W-1:0]  a_mag_c;
    logic [W-1:0]  b_mag_c;
    logic [W-1:0]  q_fix_c;
    logic [W-1:0]  r_fix_c;
    logic          rem_hi_unused;

    assign accept_c      = bus.req_valid && bus.req_ready;
    assign a_mag_c       = mag(bus.rs, bus.req_signed);
    assign b_mag_c       = mag(bus.rt, bus.req_signed);
    assign rem_hi_unused = ^div_remainder[2*W-1:W];

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.resp_valid = resp_q;

    // Operand magnitudes stay on the core inputs until the next accept
    assign div_dividend = {{W{1'b0}}, a_mag};
    assign div_divisor  = b_mag;

    div_sign_fix #(.W(W)) u_fix_q (.neg(neg_q), .val(q_raw), .y_c(q_fix_c));
    div_sign_fix #(.W(W)) u_fix_r (.neg(neg_r), .val(r_raw), .y_c(r_fix_c));

    // Sequencer FSM with registered handshake pulses and HI/LO writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rs_q      <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            q_raw     <= '0;
            r_raw     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            resp_q    <= 1'b0;
            div_start <= 1'b0;
            div_ack   <= 1'b0;
        end else begin
            div_start <= 1'b0;
            div_ack   <= 1'b0;
            resp_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        rs_q  <= bus.rs;
                        a_mag <= a_mag_c;
                        b_mag <= b_mag_c;
                        neg_q <= bus.req_signed & (bus.rs[W-1] ^ bus.rt[W-1]);
                        neg_r <= bus.req_signed & bus.rs[W-1];
                        if (bus.rt == '0) begin
                            dz    <= 1'b1;
                            state <= S_FIX;
                        end
`ifdef DIV_FASTPATH_EN
                        else if (b_mag_c == W'(1)) begin
                            dz    <= 1'b0;
                            q_raw <= a_mag_c;
                            r_raw <= '0;
                            state <= S_FIX;
                        end
`endif
                        else begin
                            dz        <= 1'b0;
                            div_start <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= CW'(DIV_CYCLES - 1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        div_ack <= 1'b1;
                        state   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    q_raw <= div_quotient;
                    r_raw <= div_remainder[W-1:0];
                    state <= S_FIX;
                end
                S_FIX: begin
                    if (dz) begin
                        lo_q <= W'(DIVZ_QUOT);
                        hi_q <= rs_q;
                    end else begin
                        lo_q <= q_fix_c;
                        hi_q <= r_fix_c;
                    end
                    resp_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural fixed-latency divide core.
module tb_div_ctrl;
    import div_pkg::*;

    localparam int unsigned CYC      = 100;
    localparam int unsigned CORE_LAT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_start;
    logic        div_ack;
    logic [63:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] core_q;
    logic [63:0] core_r;

    always #5 clk = ~clk;

    div_ctrl_if bus();

    div_ctrl #(.DIV_CYCLES(CYC), .W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .div_start    (div_start),
        .div_ack      (div_ack),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (core_q),
        .div_remainder(core_r)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t        scb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          start_cnt = 0;
    int          ack_cnt   = 0;
    int          exp_starts = 0;
    int          exp_acks   = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    // Core model: results valid CORE_LAT clocks after start is sampled, garbage otherwise
    int          ccnt;
    logic [63:0] ca;
    logic [31:0] cb;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ccnt   <= 0;
            ca     <= '0;
            cb     <= '0;
            core_q <= 32'hDEAD_BEEF;
            core_r <= 64'hBADC_0FFE_E0DD_F00D;
        end else begin
            if (div_start) begin
                ccnt   <= CORE_LAT;
                ca     <= div_dividend;
                cb     <= div_divisor;
                core_q <= 32'hDEAD_BEEF;
                core_r <= 64'hBADC_0FFE_E0DD_F00D;
            end else if (ccnt != 0) begin
                ccnt <= ccnt - 1;
                if (ccnt == 1) begin
                    core_q <= 32'(ca / {32'b0, cb});
                    core_r <= ca % {32'b0, cb};
                end
            end
            if (div_ack) begin
                core_q <= 32'hDEAD_BEEF;
                core_r <= 64'hBADC_0FFE_E0DD_F00D;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Response monitor and handshake-rule checks
    always @(negedge clk) begin
        if (!rst) begin
            if (div_start || div_ack)
                check("start_ack_excl", 64'(div_start & div_ack), 64'd0);
            if (div_ack) begin
                check("dividend_hold", div_dividend, ca);
                check("divisor_hold", 64'(div_divisor), 64'(cb));
            end
            if (div_start) start_cnt++;
            if (div_ack) ack_cnt++;
            if (bus.resp_valid) begin
                if (scb.size() == 0) begin
                    check("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    mon_e = scb.pop_front();
                    check({mon_e.tag, "_lo"}, 64'(bus.lo), 64'(mon_e.lo));
                    check({mon_e.tag, "_hi"}, 64'(bus.hi), 64'(mon_e.hi));
                    check({mon_e.tag, "_lat"}, 64'(cyc), 64'(mon_e.cyc));
                    last_hi = mon_e.hi;
                    last_lo = mon_e.lo;
                end
            end
        end
    end

    task automatic send(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, output int acc, output int lat);
        exp_t        e;
        longint      sa;
        longint      sd;
        longint      q;
        longint      r;
        logic [31:0] bmag;
        int          n;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_signed = sgn;
        bus.rs         = a;
        bus.rt         = b;
        n = 0;
        while (!bus.req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept_timeout"}, 64'(n >= 1000), 64'd0);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;
        if (b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
            lat  = 1;
        end else begin
            if (sgn) begin
                sa = $signed(a);
                sd = $signed(b);
            end else begin
                sa = {32'b0, a};
                sd = {32'b0, b};
            end
            q    = sa / sd;
            r    = sa % sd;
            e.lo = q[31:0];
            e.hi = r[31:0];
            bmag = (sgn && b[31]) ? 32'(-b) : b;
            lat  = CYC + 3;
`ifdef DIV_FASTPATH_EN
            if (bmag == 32'd1) lat = 1;
`endif
            if (lat != 1) begin
                exp_starts++;
                exp_acks++;
            end
        end
        e.cyc = acc + lat;
        e.tag = tag;
        scb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (scb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 64'(scb.size()), 64'd0);
        repeat (3) @(negedge clk);
        check({tag, "_hold_hi"}, 64'(bus.hi), 64'(last_hi));
        check({tag, "_hold_lo"}, 64'(bus.lo), 64'(last_lo));
        check({tag, "_starts"}, 64'(start_cnt), 64'(exp_starts));
        check({tag, "_acks"}, 64'(ack_cnt), 64'(exp_acks));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hi"}, 64'(bus.hi), 64'd0);
        check({tag, "_lo"}, 64'(bus.lo), 64'd0);
        check({tag, "_resp"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_start"}, 64'(div_start), 64'd0);
        check({tag, "_ack"}, 64'(div_ack), 64'd0);
        check({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_dividend"}, div_dividend, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, l1, l2, acc, lat;
        bus.req_valid  = 1'b0;
        bus.req_signed = 1'b0;
        bus.rs         = '0;
        bus.rt         = '0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        send("u100_7", 1'b0, 32'd100, 32'd7, acc, lat);
        drain("u100_7");

        send("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, acc, lat);
        drain("s_m7_2");
        send("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, acc, lat);
        drain("s_7_m2");

        send("dz_s", 1'b1, 32'h1234, 32'd0, acc, lat);
        drain("dz_s");
        send("dz_u", 1'b0, 32'h1234, 32'd0, acc, lat);
        drain("dz_u");

        send("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, a1, l1);
        send("b2b", 1'b0, 32'd50, 32'd5, a2, l2);
        check("b2b_accept", 64'(a2), 64'(a1 + l1 + 1));
        drain("b2b");

        send("fast", 1'b1, 32'h0000_0011, 32'hFFFF_FFFF, acc, lat);
        drain("fast");
        send("u_by1", 1'b0, 32'hCAFE_0001, 32'd1, acc, lat);
        drain("u_by1");

        // Abort a request mid-WAIT; nothing may come out of it
        send("abort", 1'b0, 32'd1000, 32'd3, acc, lat);
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("mid_rst");
        scb.delete();
        exp_acks--;
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        send("after_rst", 1'b0, 32'd9, 32'd3, acc, lat);
        drain("after_rst");

        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i[0]) rb = rb >> $urandom_range(28, 4);
            if (rb == 32'd0) rb = 32'd13;
            send("rand", i[1], ra, rb, acc, lat);
            drain("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
